clock_display_scan: RTL

- Downstream consumer of digital_clock. Takes binary sec/min/hr and drives a 6-digit, common-anode, time-multiplexed 7-segment display in HH.MM.SS form.
- Converts each field to two BCD digits. Snapshots the inputs once per scan frame so a frame never mixes old and new time values (no tearing).
- Sits between the clock core and the board display pins.

---
 rtl/clock_display_scan.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/clock_display_scan.sv
// Six-digit common-anode 7-segment scanner for HH.MM.SS time with per-frame input snapshot.
// Optional macro LEADING_ZERO_BLANK_EN blanks the hour tens digit when the hour is below 10.
module clock_display_scan #(
    parameter int SCAN_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] sec,
    input  logic [6:0] min,
    input  logic [4:0] hr,
    output logic [6:0] seg_n,
    output logic       dp_n,
    output logic [5:0] an_n
);

    localparam logic [15:0] DIV_LAST  = 16'(SCAN_DIV - 1);
    localparam logic [6:0]  SEG_DASH  = 7'b0111111;
    localparam logic [6:0]  SEG_BLANK = 7'b1111111;

    logic [15:0] r_div_cnt;
    logic [2:0]  r_digit;
    logic        r_first;
    logic [6:0]  r_sec;
    logic [6:0]  r_min;
    logic [4:0]  r_hr;

    logic        w_tick;
    logic        w_capture;
    logic        w_blank;
    logic        w_invalid;
    logic [6:0]  w_field;
    logic [3:0]  w_bcd;
    logic [6:0]  w_seg;
    logic [5:0]  w_an;
    logic        w_dp;

    function automatic logic [3:0] bcd_tens(input logic [6:0] v);
        return 4'(v / 7'd10);
    endfunction

    function automatic logic [3:0] bcd_ones(input logic [6:0] v);
        return 4'(v % 7'd10);
    endfunction

    function automatic logic [6:0] seg_font(input logic [3:0] v);
        logic [6:0] f;
        case (v)
            4'd0:    f = 7'b1000000;
            4'd1:    f = 7'b1111001;
            4'd2:    f = 7'b0100100;
            4'd3:    f = 7'b0110000;
            4'd4:    f = 7'b0011001;
            4'd5:    f = 7'b0010010;
            4'd6:    f = 7'b0000010;
            4'd7:    f = 7'b1111000;
            4'd8:    f = 7'b0000000;
            4'd9:    f = 7'b0010000;
            default: f = SEG_DASH;
        endcase
        return f;
    endfunction

    assign w_tick    = (r_div_cnt == DIV_LAST);
    // Snapshot only at the frame wrap so a single frame never mixes two time values.
    assign w_capture = r_first | (w_tick & (r_digit == 3'd5));

`ifdef LEADING_ZERO_BLANK_EN
    assign w_blank = (r_digit == 3'd5) && (r_hr < 5'd10);
`else
    assign w_blank = 1'b0;
`endif

    // Select the shadow field and digit for the current scan position and encode it.
    always_comb begin
        w_field   = 7'd0;
        w_invalid = 1'b0;
        case (r_digit)
            3'd0, 3'd1: begin
                w_field   = r_sec;
                w_invalid = (r_sec > 7'd59);
            end
            3'd2, 3'd3: begin
                w_field   = r_min;
                w_invalid = (r_min > 7'd59);
            end
            3'd4, 3'd5: begin
                w_field   = {2'b00, r_hr};
                w_invalid = (r_hr > 5'd23);
            end
            default: begin
                w_field   = 7'd0;
                w_invalid = 1'b0;
            end
        endcase
        if (r_digit[0]) begin
            w_bcd = bcd_tens(w_field);
        end else begin
            w_bcd = bcd_ones(w_field);
        end
        // Dash outranks blanking so a bad hour is always visible.
        if (w_invalid) begin
            w_seg = SEG_DASH;
        end else if (w_blank) begin
            w_seg = SEG_BLANK;
        end else begin
            w_seg = seg_font(w_bcd);
        end
    end

    assign w_an = ~(6'b000001 << r_digit);
    assign w_dp = ~((r_digit == 3'd2) || (r_digit == 3'd4));

    // Prescaler, digit index, shadow capture and registered display outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div_cnt <= 16'd0;
            r_digit   <= 3'd0;
            r_first   <= 1'b1;
            r_sec     <= 7'd0;
            r_min     <= 7'd0;
            r_hr      <= 5'd0;
            seg_n     <= SEG_BLANK;
            dp_n      <= 1'b1;
            an_n      <= 6'b111111;
        end else begin
            if (w_tick) begin
                r_div_cnt <= 16'd0;
                if (r_digit == 3'd5) begin
                    r_digit <= 3'd0;
                end else begin
                    r_digit <= r_digit + 3'd1;
                end
            end else begin
                r_div_cnt <= r_div_cnt + 16'd1;
            end
            if (w_capture) begin
                r_sec <= sec;
                r_min <= min;
                r_hr  <= hr;
            end
            r_first <= 1'b0;
            seg_n   <= w_seg;
            dp_n    <= w_dp;
            an_n    <= w_an;
        end
    end

endmodule
